// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 2-stage multiplier plus radix-2 restoring divider, results tagged for the ROB.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |lhs|<|rhs| skip the iteration loop.
module muldiv_unit #(
   parameter int XLEN      = 32,
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear_in,
   input  logic                 cal_signal,
   input  logic [2:0]           opcode,
   input  logic [XLEN-1:0]      lhs,
   input  logic [XLEN-1:0]      rhs,
   input  logic [ROB_WIDTH-1:0] tag,
   output logic                 ready_out,
   output logic                 done_out,
   output logic [XLEN-1:0]      result_out,
   output logic [ROB_WIDTH-1:0] tag_out
);
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ITER, S_DONE} div_state_e;

   div_state_e           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [XLEN-1:0]      quot_q, quot_d, rem_q, rem_d, divisor_q, divisor_d;
   logic [1:0]           div_op_q, div_op_d;
   logic                 q_neg_q, q_neg_d, r_neg_q, r_neg_d, early_q, early_d;
   logic [ROB_WIDTH-1:0] div_tag_q, div_tag_d;

   logic                 s1_valid_q, s1_valid_d;
   logic [XLEN-1:0]      s1_lhs_q, s1_lhs_d, s1_rhs_q, s1_rhs_d;
   logic [1:0]           s1_op_q, s1_op_d;
   logic [ROB_WIDTH-1:0] s1_tag_q, s1_tag_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [XLEN-1:0]      s2_result_q, s2_result_d;
   logic [ROB_WIDTH-1:0] s2_tag_q, s2_tag_d;

   logic                 done_q, done_d;
   logic [XLEN-1:0]      result_q, result_d;
   logic [ROB_WIDTH-1:0] tag_q, tag_d;

   logic                 accept, mul_accept, div_accept;
   logic                 a_sx, b_sx;
   logic [2*XLEN-1:0]    mul_a, mul_b, mul_prod;
   logic                 sgn, l_neg, r_neg_in, div_zero;
   logic [XLEN-1:0]      abs_l, abs_r, q_fix, r_fix;
   logic [XLEN:0]        trial, diff;

   assign ready_out  = (state_q == S_IDLE);
   assign done_out   = done_q;
   assign result_out = result_q;
   assign tag_out    = tag_q;

   assign accept     = cal_signal & ready_out & ~clear_in;
   assign mul_accept = accept & ~opcode[2];
   assign div_accept = accept & opcode[2];

   // Operands are extended to 2*XLEN so one unsigned multiply covers all four sign modes.
   always_comb begin
      a_sx        = (s1_op_q == 2'd1) || (s1_op_q == 2'd2);
      b_sx        = (s1_op_q == 2'd1);
      mul_a       = {{XLEN{a_sx & s1_lhs_q[XLEN-1]}}, s1_lhs_q};
      mul_b       = {{XLEN{b_sx & s1_rhs_q[XLEN-1]}}, s1_rhs_q};
      mul_prod    = mul_a * mul_b;
      s2_result_d = (s1_op_q == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
   end

   always_comb begin
      sgn      = ~div_op_q[0];
      l_neg    = sgn & quot_q[XLEN-1];
      r_neg_in = sgn & divisor_q[XLEN-1];
      abs_l    = l_neg ? -quot_q : quot_q;
      abs_r    = r_neg_in ? -divisor_q : divisor_q;
      div_zero = (divisor_q == '0);
      trial    = {rem_q, quot_q[XLEN-1]};
      diff     = trial - {1'b0, divisor_q};
      q_fix    = q_neg_q ? -quot_q : quot_q;
      r_fix    = r_neg_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      divisor_d  = divisor_q;
      div_op_d   = div_op_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      early_d    = early_q;
      div_tag_d  = div_tag_q;

      s1_valid_d = mul_accept;
      s1_lhs_d   = s1_lhs_q;
      s1_rhs_d   = s1_rhs_q;
      s1_op_d    = s1_op_q;
      s1_tag_d   = s1_tag_q;
      if (mul_accept) begin
         s1_lhs_d = lhs;
         s1_rhs_d = rhs;
         s1_op_d  = opcode[1:0];
         s1_tag_d = tag;
      end
      s2_valid_d = s1_valid_q;
      s2_tag_d   = s1_tag_q;

      done_d   = s2_valid_q;
      result_d = result_q;
      tag_d    = tag_q;
      if (s2_valid_q) begin
         result_d = s2_result_q;
         tag_d    = s2_tag_q;
      end

      case (state_q)
         S_IDLE: begin
            if (div_accept) begin
               state_d   = S_SETUP;
               quot_d    = lhs;
               divisor_d = rhs;
               div_op_d  = opcode[1:0];
               div_tag_d = tag;
            end
         end
         S_SETUP: begin
            // quot_q holds the dividend and shifts quotient bits in from the bottom.
            quot_d    = abs_l;
            divisor_d = abs_r;
            rem_d     = '0;
            cnt_d     = '0;
            q_neg_d   = (l_neg ^ r_neg_in) & ~div_zero;
            r_neg_d   = l_neg;
            early_d   = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            if (div_zero) begin
               early_d = 1'b1;
               quot_d  = '1;
               rem_d   = abs_l;
            end else if (sgn && (quot_q == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_q == '1)) begin
               early_d = 1'b1;
               rem_d   = '0;
            end else if (abs_l < abs_r) begin
               early_d = 1'b1;
               quot_d  = '0;
               rem_d   = abs_l;
            end
`endif
            state_d = S_ITER;
         end
         S_ITER: begin
            if (early_q) begin
               state_d = S_DONE;
            end else begin
               quot_d = {quot_q[XLEN-2:0], ~diff[XLEN]};
               rem_d  = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            result_d = div_op_q[1] ? r_fix : q_fix;
            tag_d    = div_tag_q;
         end
         default: state_d = S_IDLE;
      endcase

      if (clear_in) begin
         state_d    = S_IDLE;
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         divisor_q   <= '0;
         div_op_q    <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         early_q     <= 1'b0;
         div_tag_q   <= '0;
         s1_valid_q  <= 1'b0;
         s1_lhs_q    <= '0;
         s1_rhs_q    <= '0;
         s1_op_q     <= '0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_tag_q    <= '0;
         done_q      <= 1'b0;
         result_q    <= '0;
         tag_q       <= '0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         divisor_q   <= divisor_d;
         div_op_q    <= div_op_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         early_q     <= early_d;
         div_tag_q   <= div_tag_d;
         s1_valid_q  <= s1_valid_d;
         s1_lhs_q    <= s1_lhs_d;
         s1_rhs_q    <= s1_rhs_d;
         s1_op_q     <= s1_op_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_tag_q    <= s2_tag_d;
         done_q      <= done_d;
         result_q    <= result_d;
         tag_q       <= tag_d;
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases plus random ops scored against a plain-arithmetic model.
module tb_muldiv_unit;
   localparam int XLEN      = 32;
   localparam int ROB_WIDTH = 4;
   localparam int DIV_LAT   = XLEN + 2;
`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n, rdy, clear, cal;
   logic [2:0]           opcode;
   logic [XLEN-1:0]      lhs, rhs;
   logic [ROB_WIDTH-1:0] tag;
   logic                 ready_out, done_out;
   logic [XLEN-1:0]      result_out;
   logic [ROB_WIDTH-1:0] tag_out;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(XLEN), .ROB_WIDTH(ROB_WIDTH)) dut (
      .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .clear_in(clear), .cal_signal(cal),
      .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag),
      .ready_out(ready_out), .done_out(done_out), .result_out(result_out), .tag_out(tag_out)
   );

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
      int unsigned due;
      bit          is_div;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int unsigned rcyc = 0;
   bit          last_rdy = 1'b0;
   bit          mon_en = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, p;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            up = ua / ub; return up[31:0];
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            up = ua % ub; return up[31:0];
         end
      endcase
   endfunction

   function automatic int unsigned div_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bit          s;
      logic [31:0] ma, mb;
      bit          trivial;
      s  = !op[0];
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      trivial = (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
      return (EARLY_EN && trivial) ? 3 : DIV_LAT;
   endfunction

   function automatic bit model_busy();
      foreach (exp_q[i]) if (exp_q[i].is_div && exp_q[i].due > cyc) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return $urandom_range(0, 20);
         default: return $urandom();
      endcase
   endfunction

   // Drives one issue strobe; the model alone decides whether the unit should take it.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, output int unsigned e_edge);
      bit   acc;
      exp_t e;
      @(negedge clk);
      acc    = rdy && !clear && rst_n && !model_busy();
      cal    = 1'b1;
      opcode = op;
      lhs    = a;
      rhs    = b;
      tag    = t;
      @(posedge clk); #1;
      cal    = 1'b0;
      e_edge = cyc;
      if (acc) begin
         e.res    = ref_result(op, a, b);
         e.tag    = t;
         e.is_div = op[2];
         e.due    = cyc + (op[2] ? div_latency(op, a, b) : 2);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      check_eq("drain", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      last_rdy <= rdy;
      rcyc     <= rcyc + 1;
      if (rdy) cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (mon_en && last_rdy) begin
         check_eq("ready", ready_out, model_busy() ? 32'd0 : 32'd1);
         if (done_out) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_done", done_out, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("done_cycle", cyc, mon_e.due);
               check_eq("result", result_out, mon_e.res);
               check_eq("tag", tag_out, mon_e.tag);
            end
         end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            check_eq("missing_done", done_out, 32'd1);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned e0, e1, r0;
      logic [31:0] held;
      rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; cal = 1'b0;
      opcode = '0; lhs = '0; rhs = '0; tag = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_done", done_out, 0);
      check_eq("rst_result", result_out, 0);
      check_eq("rst_tag", tag_out, 0);
      check_eq("rst_ready", ready_out, 1);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Back-to-back multiplies, then high-half variants.
      issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 4'd1, e0);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, e1);
      issue(3'd1, 32'h8000_0000, 32'h8000_0000, 4'd3, e1);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, e1);
      wait_drain();

      // Signed divide with a multiply attempted while the divider is busy.
      issue(3'd4, -32'sd20, 32'd3, 4'd5, e0);
      repeat (3) @(posedge clk);
      issue(3'd0, 32'd5, 32'd6, 4'd7, e1);
      wait_drain();
      issue(3'd6, -32'sd20, 32'd3, 4'd6, e0);
      wait_drain();

      // Special results.
      issue(3'd5, 32'd100, 32'd0, 4'd1, e0);              wait_drain();
      issue(3'd6, 32'd100, 32'd0, 4'd2, e0);              wait_drain();
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd3, e0); wait_drain();
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4, e0); wait_drain();
      issue(3'd4, -32'sd7, 32'd0, 4'd5, e0);              wait_drain();
      issue(3'd6, -32'sd7, 32'd0, 4'd6, e0);              wait_drain();
      issue(3'd4, -32'sd3, 32'd10, 4'd7, e0);             wait_drain();
      issue(3'd6, -32'sd3, 32'd10, 4'd8, e0);             wait_drain();

      // Flush mid-divide, then a multiply right after.
      issue(3'd4, 32'd1000, 32'd7, 4'd8, e0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      exp_q.delete();
      check_eq("clear_ready", ready_out, 1);
      issue(3'd0, 32'd3, 32'd4, 4'd9, e1);
      wait_drain();

      // Flush kills a multiply in s1 and drops a strobe in the same cycle.
      issue(3'd0, 32'd11, 32'd13, 4'd10, e0);
      clear = 1'b1;
      issue(3'd1, 32'd11, 32'd13, 4'd11, e1);
      clear = 1'b0;
      exp_q.delete();
      repeat (4) @(negedge clk);

      // Stall mid-divide, then stall while the done pulse is up.
      issue(3'd4, 32'd12345, -32'sd17, 4'd11, e0);
      r0 = rcyc;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rdy = 1'b0;
      repeat (5) @(negedge clk);
      rdy = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done_out) break;
      end
      check_eq("hold_latency", rcyc - r0, DIV_LAT + 5);
      held = ref_result(3'd4, 32'd12345, -32'sd17);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("held_done", done_out, 1);
         check_eq("held_result", result_out, held);
      end
      rdy = 1'b1;
      @(negedge clk);
      check_eq("pulse_ends", done_out, 0);
      wait_drain();

      // Reset while a multiply is in flight.
      issue(3'd0, 32'd9, 32'd9, 4'd12, e0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      check_eq("midrst_done", done_out, 0);
      check_eq("midrst_result", result_out, 0);
      check_eq("midrst_tag", tag_out, 0);
      check_eq("midrst_ready", ready_out, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Random traffic with occasional stalls.
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk);
            rdy = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rdy = 1'b1;
         end
         issue(3'($urandom_range(0, 7)), pick(), pick(), 4'($urandom_range(0, 15)), e0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      wait_drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M execution unit alongside the single-cycle ALU, fed by the RS and broadcasting results with a ROB tag.
- Multiply ops use a 2-stage pipeline; divide/remainder ops use an iterative radix-2 restoring divider.
- Accepts a new op each cycle except while a divide is in flight.
- Supports flush on misprediction.

Parameters:
- XLEN, 32, operand/result width (even, >=8)
- ROB_WIDTH, 4, tag width

Ports:
- clk_in  input  1  clock; all state updates on posedge
- rst_in  input  1  synchronous, active-low reset
- rdy_in  input  1  global ready; low freezes all state and outputs
- clear_in  input  1  flush; kills every in-flight op
- cal_signal  input  1  issue strobe from RS; valid only when ready_out is high
- opcode  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- lhs  input  XLEN  rs1 value
- rhs  input  XLEN  rs2 value
- tag  input  ROB_WIDTH  ROB index of the op
- ready_out  output  1  unit can accept an op this cycle
- done_out  output  1  one-cycle result pulse, broadcast to RS, LSB and ROB
- result_out  output  XLEN  result, valid when done_out is high
- tag_out  output  ROB_WIDTH  tag of the result

Behaviour:
- Reset (rst_in==0 at posedge): done_out=0, result_out=0, tag_out=0, ready_out=1, mul pipeline valid bits=0, divider state=IDLE. Reset overrides rdy_in and clear_in; reset mid-divide aborts it with no done pulse.
- rdy_in==0: no state change. done_out, result_out and tag_out hold their values. A held done_out pulse completes on the next rdy cycle.
- Accept: an op is accepted at a posedge with rdy_in=1, cal_signal=1, ready_out=1, clear_in=0. cal_signal while ready_out=0 is a protocol error; the unit ignores it.
- ready_out = (div_state==IDLE), combinational from state.
- MUL path: 2 stages, s1 captures operands, opcode and tag; s2 registers the result.
  - Accepted at edge E -> done_out=1 after edge E+2.
  - Back-to-back accepts yield back-to-back done pulses, in order.
  - Full 2*XLEN product: MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
- DIV FSM: IDLE -> SETUP -> ITER -> DONE -> IDLE.
  - SETUP: latch |lhs| and |rhs| (abs only for signed ops), quotient sign, remainder sign and tag.
  - ITER: XLEN cycles, 5-bit (clog2 XLEN) counter, one quotient bit per cycle.
  - DONE: apply signs, drive done_out for one cycle.
  - Accepted at edge E -> done_out=1 after edge E+XLEN+2 (34 for XLEN=32).
  - ready_out returns high in the cycle done_out is high, so a new op may be accepted on that edge.
- Ordering: no MUL is accepted while a divide is busy. A DIV accepted while MULs are in s1/s2 cannot collide with them. Result-port conflicts are therefore impossible; a bench assertion checks this.
- Required RISC-V special results (XLEN=32):
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> lhs.
  - Signed overflow (lhs=0x80000000, rhs=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
  - Sign fix-up must not negate the divide-by-zero quotient.
- clear_in==1 at a rdy posedge:
  - All mul valid bits are cleared and the divider returns to IDLE.
  - done_out=0 after that edge, even if a result was due.
  - cal_signal in the same cycle is dropped.
  - ready_out=1 from the next cycle.
- Simultaneous clear_in and done_out due: clear wins, no pulse.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in SETUP, divide-by-zero, signed overflow, and |lhs|<|rhs| skip ITER and go directly to DONE. Latency is E+3 for these cases; results are identical to the full iteration. The |lhs|<|rhs| case gives quotient 0 and remainder lhs.
- Undefined: every divide takes E+XLEN+2 cycles.

Test Plan:
- MUL 7 * -3 (0x00000007, 0xFFFFFFFD) then MULHU 0xFFFFFFFF * 0xFFFFFFFF, tags 1 and 2, on consecutive edges -> done on E+2 with 0xFFFFFFEB tag 1, then E+3 with 0xFFFFFFFE tag 2.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -20/3 tag 5 -> done at E+34 with 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE. ready_out stays low E+1..E+33, and a MUL issued then is ignored.
- DIVU 100/0 -> 0xFFFFFFFF; REM 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. With MULDIV_EARLY_OUT_EN, each completes at E+3.
- DIV in flight, clear_in pulsed at E+10 -> no done_out ever, ready_out=1 at E+11. A MUL issued at E+11 -> done at E+13.
- Hold rdy_in=0 for 5 cycles mid-divide -> done delayed exactly 5 cycles with the result unchanged. rst_in=0 mid-MUL -> no done_out, all outputs 0.
